// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe: write-back pipeline stage.
//   Captures one instruction from MEM, formats load data (byte/half/word,
//   signed/unsigned, byte offset) and drives the register-file write port
//   and the ID bypass path combinationally from the stage registers.
// Ports:
//   clk, reset                   clock, async active-high reset
//   ms_valid/ws_allowin          MEM->WB handshake
//   ms_pc/ms_ctrl/ms_alu/ms_rdata/ms_dest  incoming instruction fields
//   ws_stall, ws_flush           downstream hold, exception squash
//   ws_valid, ws_pc              held-instruction status
//   rf_we/rf_waddr/rf_wdata      register-file write (suppressed while stalled)
//   fwd_valid/fwd_dest/fwd_data  bypass to ID (visible while stalled)
module wb_stage_pipe #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int CTRL_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ms_valid,
  output logic              ws_allowin,
  input  logic [31:0]       ms_pc,
  input  logic [CTRL_W-1:0] ms_ctrl,
  input  logic [DW-1:0]     ms_alu,
  input  logic [DW-1:0]     ms_rdata,
  input  logic [AW-1:0]     ms_dest,
  input  logic              ws_stall,
  input  logic              ws_flush,
  output logic              ws_valid,
  output logic [31:0]       ws_pc,
  output logic              rf_we,
  output logic [AW-1:0]     rf_waddr,
  output logic [DW-1:0]     rf_wdata,
  output logic              fwd_valid,
  output logic [AW-1:0]     fwd_dest,
  output logic [DW-1:0]     fwd_data
);

  // Only ctrl[6:0] and the low 32 bits of the read word matter, so the
  // reserved control bits are never stored and cannot reach an output.
  typedef struct packed {
    logic [31:0]   pc;
    logic [6:0]    ctrl;
    logic [DW-1:0] alu;
    logic [31:0]   rdata;
    logic [AW-1:0] dest;
  } stage_t;

  logic   valid_q, valid_d;
  stage_t stage_q, stage_d;
  logic   take;

  assign ws_allowin = !valid_q || !ws_stall;
  // Flush drops the incoming instruction as well as the held one.
  assign take       = ms_valid && ws_allowin && !ws_flush;

  always_comb begin
    valid_d = valid_q;
    stage_d = stage_q;
    if (ws_flush)        valid_d = 1'b0;
    else if (ws_allowin) valid_d = ms_valid;
    if (take) begin
      stage_d.pc    = ms_pc;
      stage_d.ctrl  = ms_ctrl[6:0];
      stage_d.alu   = ms_alu;
      stage_d.rdata = ms_rdata[31:0];
      stage_d.dest  = ms_dest;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      stage_q <= '0;
    end else begin
      valid_q <= valid_d;
      stage_q <= stage_d;
    end
  end

  // Load formatting
  logic [1:0]    ld_off;
  logic [1:0]    ld_size;
  logic          ld_uns;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;
  logic [DW-1:0] ld_data;
  logic [DW-1:0] wdata;
  logic          wr_en;

  assign ld_off  = stage_q.ctrl[6:5];
  assign ld_size = stage_q.ctrl[3:2];
  assign ld_uns  = stage_q.ctrl[4];
  assign ld_b    = stage_q.rdata[{ld_off, 3'b000} +: 8];
  // Half-word: off[0] is ignored, only the upper/lower half is selected.
  assign ld_h    = ld_off[1] ? stage_q.rdata[31:16] : stage_q.rdata[15:0];

  always_comb begin
    ld_data = '0;
    case (ld_size)
      2'b00:   ld_data = {{(DW-8){ld_b[7] & ~ld_uns}}, ld_b};
      2'b01:   ld_data = {{(DW-16){ld_h[15] & ~ld_uns}}, ld_h};
      default: ld_data = {{(DW-32){stage_q.rdata[31] & ~ld_uns}}, stage_q.rdata};
    endcase
  end

  generate
    if (DW > 32) begin : g_rdata_hi
      logic unused_rdata_hi;
      assign unused_rdata_hi = ^ms_rdata[DW-1:32];
    end
    if (CTRL_W > 7) begin : g_ctrl_rsv
      logic unused_ctrl_rsv;
      assign unused_ctrl_rsv = ^ms_ctrl[CTRL_W-1:7];
    end
  endgenerate

  assign wdata = stage_q.ctrl[1] ? ld_data : stage_q.alu;
  assign wr_en = valid_q && stage_q.ctrl[0] && (stage_q.dest != '0);

  assign ws_valid  = valid_q;
  assign ws_pc     = stage_q.pc;
  // The write is held back while stalled so it lands exactly once, on release.
  assign rf_we     = wr_en && !ws_stall;
  assign rf_waddr  = stage_q.dest;
  assign rf_wdata  = wdata;
  assign fwd_valid = wr_en;
  assign fwd_dest  = stage_q.dest;
  assign fwd_data  = wdata;

endmodule

// File: doc/wb_stage_pipe.md
WB_STAGE_PIPE -- requirements
Module: wb_stage_pipe

Interface
REQ-001 Parameter DW, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter AW, default 5, register-address width.
REQ-003 Parameter CTRL_W, default 10, control-word width; minimum 7.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 ms_valid  in  1  MEM stage presents a valid instruction.
REQ-007 ws_allowin  out  1  WB can accept an instruction this cycle.
REQ-008 ms_pc  in  32  instruction PC.
REQ-009 ms_ctrl  in  CTRL_W  control word: [0] RegWrite, [1] Mem2Reg (1 = load data), [3:2] size (00 byte, 01 half, 10/11 word), [4] unsigned load, [6:5] byte offset; remaining bits reserved.
REQ-010 ms_alu  in  DW  ALU result.
REQ-011 ms_rdata  in  DW  raw memory read word.
REQ-012 ms_dest  in  AW  destination register.
REQ-013 ws_stall  in  1  downstream hold (trace compare / debug).
REQ-014 ws_flush  in  1  exception flush; squashes the held instruction.
REQ-015 ws_valid  out  1  WB holds a valid instruction.
REQ-016 ws_pc  out  32  PC of the held instruction.
REQ-017 rf_we  out  1  register-file write enable.
REQ-018 rf_waddr  out  AW  register-file write address.
REQ-019 rf_wdata  out  DW  register-file write data.
REQ-020 fwd_valid, fwd_dest (AW), fwd_data (DW)  out  bypass to ID; same value as the rf_* write.

Function
REQ-021 ws_allowin SHALL equal !ws_valid || !ws_stall, combinationally.
REQ-022 Transfer SHALL occur on a rising edge where ms_valid && ws_allowin; all ms_* inputs are captured into stage registers, and ws_valid is set to 1.
REQ-023 When ws_allowin=1 and ms_valid=0, ws_valid SHALL become 0 on the next edge.
REQ-024 When ws_valid=1 and ws_stall=1, all stage registers SHALL hold their values.
REQ-025 ws_flush=1 SHALL clear ws_valid on the next edge; flush takes priority over a simultaneous transfer, and the incoming instruction is dropped.
REQ-026 Latency: an instruction SHALL drive rf_* in the cycle after transfer, purely combinationally from the stage registers.
REQ-027 rf_we SHALL equal ws_valid && ctrl[0] && (dest != 0) && !ws_stall; while ws_stall=1, the register file is written only once, on release.
REQ-028 rf_waddr SHALL equal the registered dest; ws_pc SHALL equal the registered pc.
REQ-029 With Mem2Reg=0, rf_wdata SHALL equal the registered ALU result.
REQ-030 With Mem2Reg=1, rf_wdata SHALL be the loaded field, zero-extended if ctrl[4]=1, otherwise sign-extended to DW.
REQ-031 Byte loads SHALL select rdata[8*off+7:8*off], with off = ctrl[6:5].
REQ-032 Half loads SHALL select rdata[16*off[1]+15:16*off[1]]; off[0] is ignored.
REQ-033 Word loads SHALL ignore the offset and use rdata[31:0], extended per REQ-030 when DW=64.
REQ-034 fwd_valid SHALL equal ws_valid && ctrl[0] && (dest != 0), independent of ws_stall.
REQ-035 fwd_dest SHALL equal rf_waddr, and fwd_data SHALL equal rf_wdata.
REQ-036 Reserved ctrl bits SHALL have no effect on any output.

Reset
REQ-037 While reset=1, ws_valid, rf_we and fwd_valid SHALL be 0, and ws_pc, rf_waddr, rf_wdata, fwd_dest and fwd_data SHALL be 0, asynchronously.
REQ-038 Reset asserted mid-stall SHALL discard the held instruction; no register-file write is issued.
REQ-039 After reset deasserts, ws_allowin SHALL be 1 in the first cycle.

Verification
REQ-040 Transfer pc=0xBFC00000, ctrl=0x001, alu=0x12345678, dest=5 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x12345678, ws_pc=0xBFC00000.
REQ-041 Load with rdata=0x80FF7F01, ctrl byte/signed/off=3 -> rf_wdata=0xFFFFFF80; same with unsigned -> 0x00000080; half/signed/off=2 -> 0xFFFF80FF.
REQ-042 Transfer then ws_stall=1 for 3 cycles -> ws_allowin=0, rf_we=0, fwd_valid=1 throughout; on release, rf_we pulses for exactly one cycle.
REQ-043 ws_flush=1 coincident with ms_valid=1, ws_allowin=1 -> next cycle ws_valid=0, rf_we=0, fwd_valid=0.
REQ-044 Transfer with dest=0, RegWrite=1 -> rf_we=0, fwd_valid=0.
REQ-045 reset pulse asserted while stalled with a valid load -> all outputs 0 immediately; no write issued after release.
